// File: rtl/intt_seq_ctrl_pkg.sv
// Shared definitions for the INTT sequencer: FSM state encoding, default
// datapath geometry and a small constant helper.
package intt_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DRAIN  = 3'd5
  } ctrl_state_t;

  // Defaults track the DATA_SIZE_ARB / PE_NUMBER defines of the INTT core.
  localparam int DATA_W_DEF = 27;
  localparam int PE_NUM_DEF = 8;
  localparam int LANES_DEF  = 2 * PE_NUM_DEF;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/intt_lane_serializer.sv
// Holds the captured INTT result word and emits it one DATA_W lane at a time
// (lane 0 = LSBs first) on a valid/ready stream.
module intt_lane_serializer
  import intt_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  output logic                    last_accept
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANES*DATA_W-1:0] shadow_r;
  logic [LANE_W-1:0]       lane_r;
  logic [LANE_W-1:0]       lane_next_s;
  logic                    valid_r;
  logic                    last_r;
  logic [DATA_W-1:0]       data_r;
  logic                    advance_s;

  // Handshake decode and next lane index.
  always_comb begin
    advance_s   = valid_r && m_ready;
    last_accept = advance_s && last_r;
    if (advance_s) begin
      lane_next_s = lane_r + LANE_W'(1);
    end else begin
      lane_next_s = lane_r;
    end
  end

  // Shadow capture and lane stepping; the output word only changes on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= '0;
      lane_r   <= '0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      data_r   <= '0;
    end else if (capture) begin
      shadow_r <= data_in;
      lane_r   <= '0;
      valid_r  <= 1'b1;
      data_r   <= data_in[DATA_W-1:0];
      last_r   <= (LANES == 1);
    end else if (advance_s) begin
      if (last_r) begin
        lane_r  <= '0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
        data_r  <= '0;
      end else begin
        lane_r  <= lane_next_s;
        data_r  <= shadow_r[lane_next_s*DATA_W +: DATA_W];
        last_r  <= (lane_next_s == LAST_LANE);
      end
    end else begin
      lane_r  <= lane_r;
      valid_r <= valid_r;
      last_r  <= last_r;
      data_r  <= data_r;
    end
  end

  assign m_valid = valid_r;
  assign m_data  = data_r;
  assign m_last  = last_r;

endmodule

// File: rtl/intt_seq_ctrl.sv
// Sequencer driving the INTT core: loads twiddles/coefficients, starts the
// transform, waits for completion and streams the result lanes out.
module intt_seq_ctrl
  import intt_seq_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PE_NUM   = PE_NUM_DEF,
  parameter int N_TW     = 1024,
  parameter int N_DATA   = 1024,
  parameter int WAIT_MAX = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic                         cmd_load_tw,
  output logic                         cmd_ready,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         intt_load_w,
  output logic                         intt_load_data,
  output logic                         intt_start,
  output logic [DATA_W-1:0]            intt_din,
  input  logic                         intt_done,
  input  logic [2*PE_NUM*DATA_W-1:0]   intt_bram_out,
  output logic                         busy,
  output logic                         err_timeout
);

  localparam int LANES  = 2 * PE_NUM;
  localparam int CNT_W  = $clog2(max_int(N_TW, N_DATA) + 1);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  TW_LAST   = CNT_W'(N_TW - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(N_DATA - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  ctrl_state_t        state_r;
  ctrl_state_t        state_next_s;
  logic [CNT_W-1:0]   word_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               accept_s;
  logic               load_last_s;
  logic               capture_s;
  logic               timeout_s;
  logic               drain_done_s;

  logic               cmd_ready_r;
  logic               s_ready_r;
  logic               busy_r;
  logic               load_w_r;
  logic               load_data_r;
  logic               start_r;
  logic [DATA_W-1:0]  din_r;
  logic               err_timeout_r;

  // Next-state decode; the terminal count compares force every exit.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    load_last_s  = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_next_s = cmd_load_tw ? ST_LOAD_W : ST_LOAD_D;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        accept_s = s_valid && s_ready_r;
        if (accept_s && (word_cnt_r == TW_LAST)) begin
          load_last_s  = 1'b1;
          state_next_s = ST_LOAD_D;
        end else begin
          state_next_s = ST_LOAD_W;
        end
      end
      ST_LOAD_D: begin
        accept_s = s_valid && s_ready_r;
        if (accept_s && (word_cnt_r == DATA_LAST)) begin
          load_last_s  = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_LOAD_D;
        end
      end
      ST_START: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (intt_done) begin
          capture_s    = 1'b1;
          state_next_s = ST_DRAIN;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Accepted-word counter, shared by both load phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || load_last_s) begin
      word_cnt_r <= '0;
    end else if (accept_s) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  // Cycles spent waiting for the core; saturates at the timeout compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= '0;
    end else if (!intt_done && (wait_cnt_r != WAIT_LAST)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Registered host- and core-side outputs. Start is issued from START so it
  // lands one cycle after the last data strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_r   <= 1'b0;
      s_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
      load_w_r      <= 1'b0;
      load_data_r   <= 1'b0;
      start_r       <= 1'b0;
      din_r         <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      cmd_ready_r   <= (state_next_s == ST_IDLE);
      s_ready_r     <= (state_next_s == ST_LOAD_W) || (state_next_s == ST_LOAD_D);
      busy_r        <= (state_next_s != ST_IDLE);
      load_w_r      <= accept_s && (state_r == ST_LOAD_W);
      load_data_r   <= accept_s && (state_r == ST_LOAD_D);
      start_r       <= (state_r == ST_START);
      err_timeout_r <= timeout_s;
      if (accept_s) begin
        din_r <= s_data;
      end else begin
        din_r <= din_r;
      end
    end
  end

  intt_lane_serializer #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture_s),
    .data_in     (intt_bram_out),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .last_accept (drain_done_s)
  );

  assign cmd_ready      = cmd_ready_r;
  assign s_ready        = s_ready_r;
  assign busy           = busy_r;
  assign intt_load_w    = load_w_r;
  assign intt_load_data = load_data_r;
  assign intt_start     = start_r;
  assign intt_din       = din_r;
  assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_intt_seq_ctrl.sv
// Directed bench for intt_seq_ctrl with a small geometry: 8 twiddles, 8 data
// words, 4 output lanes, 100-cycle wait budget.
module tb_intt_seq_ctrl;

  localparam int DATA_W   = 27;
  localparam int PE_NUM   = 2;
  localparam int N_TW     = 8;
  localparam int N_DATA   = 8;
  localparam int WAIT_MAX = 100;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       cmd_valid, cmd_load_tw, cmd_ready;
  logic                       s_valid, s_ready;
  logic [DATA_W-1:0]          s_data;
  logic                       m_valid, m_last, m_ready;
  logic [DATA_W-1:0]          m_data;
  logic                       intt_load_w, intt_load_data, intt_start;
  logic [DATA_W-1:0]          intt_din;
  logic                       intt_done;
  logic [2*PE_NUM*DATA_W-1:0] intt_bram_out;
  logic                       busy, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  intt_seq_ctrl #(
    .DATA_W(DATA_W), .PE_NUM(PE_NUM), .N_TW(N_TW), .N_DATA(N_DATA), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_load_tw(cmd_load_tw), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .intt_load_w(intt_load_w), .intt_load_data(intt_load_data), .intt_start(intt_start),
    .intt_din(intt_din), .intt_done(intt_done), .intt_bram_out(intt_bram_out),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic tw);
    chk("cmd_ready_idle", {cmd_ready, busy}, 2'b10);
    cmd_valid   = 1'b1;
    cmd_load_tw = tw;
    step();
    cmd_valid   = 1'b0;
    cmd_load_tw = 1'b0;
    chk("cmd_taken", {busy, s_ready, cmd_ready}, 3'b110);
  endtask

  // Back-to-back words base..base+n-1; the first n_w go to twiddle memory.
  task automatic feed_burst(input int n, input int base, input int n_w);
    logic exp_w;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_W'(base + i);
      step();
      exp_w = (i < n_w);
      chk("load_strobe", {intt_load_w, intt_load_data, intt_start, intt_din},
          {exp_w, ~exp_w, 1'b0, DATA_W'(base + i)});
      chk("s_ready_load", s_ready, (i != n - 1));
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic check_start();
    step();
    chk("start_pulse", {intt_load_w, intt_load_data, intt_start, s_ready}, 4'b0010);
  endtask

  // Core finishes after 'delay' WAIT cycles; optional stall on one lane.
  task automatic finish_core(input int delay, input int stall_lane, input int stall_cycles);
    logic bad;
    bad           = 1'b0;
    intt_bram_out = {27'd4, 27'd3, 27'd2, 27'd1};
    m_ready       = 1'b1;
    for (int d = 0; d < delay; d++) begin
      step();
      if (intt_start || m_valid || err_timeout) bad = 1'b1;
    end
    chk("wait_quiet", bad, 1'b0);
    intt_done = 1'b1;
    step();
    intt_done = 1'b0;
    for (int lane = 0; lane < 2 * PE_NUM; lane++) begin
      chk("m_word", {m_valid, m_last, m_data},
          {1'b1, (lane == 2 * PE_NUM - 1), DATA_W'(lane + 1)});
      if (lane == stall_lane) begin
        m_ready = 1'b0;
        bad     = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          if (!m_valid || (m_data !== DATA_W'(lane + 1)) || m_last) bad = 1'b1;
        end
        chk("m_stall_hold", bad, 1'b0);
        m_ready = 1'b1;
      end
      step();
    end
    chk("drain_exit", {m_valid, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_load_tw = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; intt_done = 1'b0; intt_bram_out = '0;
    step();
    step();
    chk("reset_outputs", {cmd_ready, s_ready, m_valid, m_last, intt_load_w, intt_load_data,
                          intt_start, busy, err_timeout}, 9'd0);
    reset = 1'b0;
    step();
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    // Twiddles then data, back to back, then clean drain.
    issue_cmd(1'b1);
    feed_burst(N_TW + N_DATA, 0, N_TW);
    check_start();
    finish_core(20, -1, 0);

    // Data only with s_valid toggling; strobes follow accepted words only.
    issue_cmd(1'b0);
    for (int k = 0; k < 2 * N_DATA - 1; k++) begin
      s_valid = (k % 2 == 0);
      s_data  = DATA_W'(100 + k / 2);
      step();
      if (k % 2 == 0) begin
        chk("toggle_strobe", {intt_load_w, intt_load_data, intt_start, intt_din},
            {3'b010, DATA_W'(100 + k / 2)});
      end else begin
        chk("toggle_gap", {intt_load_w, intt_load_data, intt_start}, 3'b000);
      end
    end
    chk("s_ready_drop", s_ready, 1'b0);
    s_valid = 1'b0;
    check_start();
    finish_core(20, 1, 5);

    // Timeout: no done, pulse 100 cycles after entering WAIT.
    issue_cmd(1'b0);
    feed_burst(N_DATA, 300, 0);
    check_start();
    begin
      logic bad;
      bad = 1'b0;
      for (int j = 1; j < WAIT_MAX; j++) begin
        step();
        if (err_timeout || m_valid || !busy) bad = 1'b1;
      end
      chk("timeout_early", bad, 1'b0);
      step();
      chk("timeout_pulse", {err_timeout, busy, cmd_ready, m_valid}, 4'b1010);
      step();
      chk("timeout_single", {err_timeout, m_valid, cmd_ready}, 3'b001);
    end

    // Late done outside WAIT is ignored.
    intt_done = 1'b1;
    step();
    intt_done = 1'b0;
    chk("done_ignored_idle", {m_valid, busy, cmd_ready}, 3'b001);

    // Reset on the 4th data word, then a fresh full command.
    issue_cmd(1'b0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_W'(50 + i);
      step();
    end
    s_data = DATA_W'(53);
    reset  = 1'b1;
    step();
    chk("midload_reset_ctrl", {cmd_ready, s_ready, m_valid, m_last, intt_load_w,
                               intt_load_data, intt_start, busy, err_timeout}, 9'd0);
    chk("midload_reset_data", {m_data, intt_din}, 54'd0);
    reset   = 1'b0;
    s_valid = 1'b0;
    step();
    chk("cmd_ready_post_reset", cmd_ready, 1'b1);
    issue_cmd(1'b1);
    feed_burst(N_TW + N_DATA, 200, N_TW);
    check_start();
    finish_core(3, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
